// File: rtl/ysyx_24090003_ifu_fetch.sv
// Instruction fetch unit: holds the PC, fetches one instruction per PC over an
// AXI4-Lite-style read channel and hands it to decode with a valid/ready handshake.
module ysyx_24090003_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_araddr,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic        i_rvalid,
  output logic        o_rready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_fetch_err,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  input  logic        i_pc_update,
  input  logic [31:0] i_next_pc
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RESP_W = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_EXEC = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              launch;
  logic [XLEN-1:0]   launch_pc;
  logic              launch_aligned;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_next;
  logic [XLEN-1:0]   inst;
  logic [XLEN-1:0]   inst_next;
  logic              fetch_err;
  logic              fetch_err_next;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a launch from EXEC takes its PC straight from commit
  always_comb begin
    state_next     = state;
    launch         = 1'b0;
    launch_pc      = pc;
    launch_aligned = 1'b0;
    unique case (state)
      S_IDLE: launch = 1'b1;
      S_REQ:  if (i_arready)    state_next = S_WAIT;
      S_WAIT: if (i_rvalid)     state_next = S_HOLD;
      S_HOLD: if (i_inst_ready) state_next = S_EXEC;
      S_EXEC: begin
        if (i_pc_update) begin
          launch    = 1'b1;
          launch_pc = i_next_pc;
        end
      end
      default: state_next = S_IDLE;
    endcase
    launch_aligned = (launch_pc[1:0] == 2'b00);
    if (launch) begin
      state_next = launch_aligned ? S_REQ : S_HOLD;
    end
  end

  // Output decode and datapath next values
  always_comb begin
    o_arvalid      = (state == S_REQ);
    o_rready       = (state == S_WAIT);
    o_inst_valid   = (state == S_HOLD);
    pc_next        = pc;
    inst_next      = inst;
    fetch_err_next = fetch_err;
    if (launch) begin
      pc_next = launch_pc;
      // Misaligned PCs never reach the bus; decode sees a flagged null instruction
      if (!launch_aligned) begin
        inst_next      = XLEN'(0);
        fetch_err_next = 1'b1;
      end
    end
    if ((state == S_WAIT) && i_rvalid) begin
      inst_next      = i_rdata;
      fetch_err_next = (i_rresp != RESP_W'(0));
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc        <= RESET_PC;
      inst      <= XLEN'(0);
      fetch_err <= 1'b0;
    end else begin
      pc        <= pc_next;
      inst      <= inst_next;
      fetch_err <= fetch_err_next;
    end
  end

  assign o_araddr    = pc;
  assign o_pc        = pc;
  assign o_inst      = inst;
  assign o_fetch_err = fetch_err;

  // Decode must never see the presented instruction change before acceptance
  a_hold_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_inst_valid && !i_inst_ready) |=>
      (o_inst_valid && $stable(o_inst) && $stable(o_pc) && $stable(o_fetch_err)));

  // The request address must not move while waiting for the slave
  a_req_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_arvalid && !i_arready) |=> (o_arvalid && $stable(o_araddr)));

endmodule
